op_dispatch_q: RTL
==================

// Module: op_dispatch_q
// PURPOSE
// Parametrised successor to the FPU input decoder. Buffers CPU operand/opcode pushes in an
// in-order queue and issues each one to exactly one of NUM_UNITS execution units (unit 0=add,
// 1=mul, 2=sine by default) with a one-cycle start pulse. Sits between the CPU bus and the FP units.
// PARAMETERS
// DATA_W    32  operand width
// NUM_UNITS 3   execution unit count; op_sel and opcode_out are one-hot of this width
// DEPTH     4   queue entries; power of two, >=2
// PORTS
// clk            in   1                     clock, rising edge
// rst            in   1                     synchronous reset, active-high
// op_strobe      in   1                     push request, sampled every rising edge
// op1, op2       in   DATA_W                operands
// op_sel         in   NUM_UNITS             one-hot target unit
// unit_busy      in   NUM_UNITS             unit k cannot accept a start
// out_fifo_hold  in   1                     downstream result FIFO full; stall all issue
// op1_out,op2_out out  DATA_W               operands of the last issued op (held)
// opcode_out     out  NUM_UNITS             one-hot of the last issued op (held)
// unit_start     out  NUM_UNITS             one-cycle start pulse, at most one bit set
// cpu_hold       out  1                     queue full; CPU must not push
// q_count        out  $clog2(DEPTH+1)       occupied entries
// op_err         out  1                     one-cycle pulse: push dropped
// BEHAVIOUR
// - Reset: queue flushed, q_count=0, all outputs 0, state IDLE. Reset mid-op discards in-flight entries.
// - Push: op_strobe=1 at edge with op_sel one-hot and cpu_hold=0 -> entry written; q_count+1 after edge.
// - Drop: op_sel zero or multi-hot, or op_strobe while cpu_hold=1 -> not enqueued, op_err=1 next cycle.
// - cpu_hold = (q_count==DEPTH), registered view; a push at full is dropped even if an issue pops same edge.
// - Simultaneous push+issue when not full: q_count unchanged; pointers wrap modulo DEPTH.
// - Strict in-order issue; head-of-line blocking (a blocked head stalls ops for free units).
// - FSM:
//   IDLE  : q empty. Push -> ISSUE.
//   ISSUE : head eligible when !out_fifo_hold && !unit_busy[k], k = head op_sel.
//           If eligible: unit_start[k]=1 for exactly one cycle; op1_out/op2_out/opcode_out load
//           head; pop; -> GUARD. Otherwise -> WAIT.
//   WAIT  : hold outputs, unit_start=0; when eligible -> ISSUE.
//   GUARD : one cycle, no issue to any unit (covers unit busy-assert latency);
//           q non-empty -> ISSUE, else IDLE.
// - Latency: push at edge N into empty queue with free unit -> unit_start high cycle N+1..N+2
//   (registered). Peak throughput 1 op / 2 cycles.
// - op1_out/op2_out/opcode_out change only on issue; unit_start never asserts while out_fifo_hold=1.
// CONFIGURATION
// OP_DISPATCH_ERRCNT_EN defined: adds output err_count[15:0], +1 per op_err pulse, saturates at
//   16'hFFFF, cleared by rst.
// Undefined: port and counter absent; op_err still pulses.
// TESTING
// 1 rst, push (1,1,001) all idle -> unit_start=001 one cycle later, op1_out=1, opcode_out=001, q_count 0.
// 2 unit_busy=001, push (1,1,001),(15,15,010) -> no start; q_count=2; release busy -> start 001 then 010
//   (>=2 cycles apart).
// 3 out_fifo_hold=1, push DEPTH=4 ops -> cpu_hold=1; 5th push -> op_err pulse, q_count stays 4;
//   drop hold -> 4 starts in order.
// 4 push op_sel=000 then 011 -> two op_err pulses, q_count=0, no unit_start.
// 5 rst asserted with 3 queued ops, unit waiting -> next cycle q_count=0, all outputs 0, no later start.
// 6 ERRCNT_EN: 3 invalid pushes -> err_count=3; rst -> 0.

Source files
------------

// File: rtl/op_dispatch_q.sv
// op_dispatch_q: in-order operand/opcode queue issuing each op to one execution unit with a start pulse
// Ports: clk, rst (sync, active-high); op_strobe/op1/op2/op_sel push an op; unit_busy and
// out_fifo_hold gate issue; op1_out/op2_out/opcode_out hold the last issued op; unit_start pulses
// one-hot per issue; cpu_hold flags a full queue; q_count is occupancy; op_err pulses on a dropped push.
// Define OP_DISPATCH_ERRCNT_EN to add err_count[15:0], a saturating count of op_err pulses.
module op_dispatch_q #(
  parameter int DATA_W = 32,
  parameter int NUM_UNITS = 3,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       op_strobe,
  input  logic [DATA_W-1:0]          op1,
  input  logic [DATA_W-1:0]          op2,
  input  logic [NUM_UNITS-1:0]       op_sel,
  input  logic [NUM_UNITS-1:0]       unit_busy,
  input  logic                       out_fifo_hold,
  output logic [DATA_W-1:0]          op1_out,
  output logic [DATA_W-1:0]          op2_out,
  output logic [NUM_UNITS-1:0]       opcode_out,
  output logic [NUM_UNITS-1:0]       unit_start,
  output logic                       cpu_hold,
  output logic [$clog2(DEPTH+1)-1:0] q_count,
  output logic                       op_err
`ifdef OP_DISPATCH_ERRCNT_EN
  ,
  output logic [15:0]                err_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GUARD} state_t;
  state_t state, state_nxt;
  logic [DATA_W-1:0] mem1 [DEPTH];
  logic [DATA_W-1:0] mem2 [DEPTH];
  logic [NUM_UNITS-1:0] mems [DEPTH];
  logic [AW-1:0] rd, wr;
  logic push, issue, elig;
  logic [CW-1:0] count_nxt;
  assign cpu_hold = q_count == CW'(DEPTH);
  // a full queue drops the push even if the head pops on the same edge
  assign push = op_strobe && !cpu_hold && op_sel != '0 && (op_sel & (op_sel - NUM_UNITS'(1))) == '0;
  assign elig = !out_fifo_hold && (mems[rd] & unit_busy) == '0;
  assign count_nxt = q_count + CW'(push) - CW'(issue);
  always_comb begin
    state_nxt = state;
    issue = 1'b0;
    case (state)
      IDLE:  state_nxt = push ? ISSUE : IDLE;
      ISSUE: begin
        issue = elig;
        state_nxt = elig ? GUARD : WAIT;
      end
      WAIT:  state_nxt = elig ? ISSUE : WAIT;
      GUARD: state_nxt = count_nxt != '0 ? ISSUE : IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (push) begin
      mem1[wr] <= op1;
      mem2[wr] <= op2;
      mems[wr] <= op_sel;
    end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rd <= '0;
      wr <= '0;
      q_count <= '0;
      unit_start <= '0;
      op1_out <= '0;
      op2_out <= '0;
      opcode_out <= '0;
      op_err <= 1'b0;
    end else begin
      state <= state_nxt;
      q_count <= count_nxt;
      op_err <= op_strobe && !push;
      unit_start <= issue ? mems[rd] : '0;
      if (push) wr <= wr + AW'(1);
      if (issue) begin
        rd <= rd + AW'(1);
        op1_out <= mem1[rd];
        op2_out <= mem2[rd];
        opcode_out <= mems[rd];
      end
    end
  end
`ifdef OP_DISPATCH_ERRCNT_EN
  always_ff @(posedge clk)
    if (rst) err_count <= '0;
    else if (op_err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
`endif
endmodule
